branch_resolve_unit: RTL and testbench

- ID-stage branch resolver for the pipelined MIPS core.
- Selects forwarded operands for the ID equality comparator (CMP_A/CMP_B) and consumes its 1-bit result (CMP_EQ).
- Sequences stall cycles when a branch source operand is still in flight.
- Issues PC_SRC_D and the IF/ID flush for taken beq/bne.

---
 rtl/branch_resolve_unit.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand forwarding, hazard stall sequencing and branch redirect.
// Optional BRANCH_STATS_EN adds saturating branch/taken/stall event counters.
module branch_resolve_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BRANCH_D,
  input  logic             BNE_D,
  input  logic [4:0]       RS_D,
  input  logic [4:0]       RT_D,
  input  logic [WIDTH-1:0] RD1_D,
  input  logic [WIDTH-1:0] RD2_D,
  input  logic [WIDTH-1:0] ALU_OUT_M,
  input  logic [4:0]       WRITE_REG_E,
  input  logic [4:0]       WRITE_REG_M,
  input  logic             REG_WRITE_E,
  input  logic             MEM_TO_REG_E,
  input  logic             REG_WRITE_M,
  input  logic             MEM_TO_REG_M,
  output logic [WIDTH-1:0] CMP_A,
  output logic [WIDTH-1:0] CMP_B,
  input  logic             CMP_EQ,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic             FLUSH_E,
  output logic             PC_SRC_D,
  output logic             FLUSH_D,
  output logic             BUSY
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      BR_COUNT,
  output logic [15:0]      BR_TAKEN_COUNT,
  output logic [15:0]      STALL_COUNT
`endif
);

  typedef enum logic [1:0] {StIdle, StStall, StResolve} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic rs_nz, rt_nz;
  logic hex_rs, hex_rt, lex_rs, lex_rt, lm_rs, lm_rt;
  logic need_one, need_two;
  logic stall, resolve;

  assign rs_nz = (RS_D != 5'd0);
  assign rt_nz = (RT_D != 5'd0);

  assign hex_rs = rs_nz & REG_WRITE_E & (WRITE_REG_E == RS_D) & ~MEM_TO_REG_E;
  assign hex_rt = rt_nz & REG_WRITE_E & (WRITE_REG_E == RT_D) & ~MEM_TO_REG_E;
  assign lex_rs = rs_nz & REG_WRITE_E & (WRITE_REG_E == RS_D) & MEM_TO_REG_E;
  assign lex_rt = rt_nz & REG_WRITE_E & (WRITE_REG_E == RT_D) & MEM_TO_REG_E;
  assign lm_rs  = rs_nz & MEM_TO_REG_M & (WRITE_REG_M == RS_D);
  assign lm_rt  = rt_nz & MEM_TO_REG_M & (WRITE_REG_M == RT_D);

  // A load in EX dominates: it needs two bubbles regardless of the other source.
  assign need_two = lex_rs | lex_rt;
  assign need_one = hex_rs | hex_rt | lm_rs | lm_rt;

  // Only ALU results are forwardable from MEM; load data arrives via the write-first regfile.
  always_comb begin
    CMP_A = RD1_D;
    CMP_B = RD2_D;
    if (rs_nz && (RS_D == WRITE_REG_M) && REG_WRITE_M && !MEM_TO_REG_M) CMP_A = ALU_OUT_M;
    if (rt_nz && (RT_D == WRITE_REG_M) && REG_WRITE_M && !MEM_TO_REG_M) CMP_B = ALU_OUT_M;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    resolve = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (BRANCH_D) begin
          if (!need_one && !need_two) begin
            resolve = 1'b1;
          end else begin
            stall = 1'b1;
            if (need_two) begin
              state_d = StStall;
              cnt_d   = 2'd1;
            end else begin
              state_d = StResolve;
            end
          end
        end
      end
      StStall: begin
        if (!BRANCH_D) begin
          state_d = StIdle;
          cnt_d   = 2'd0;
        end else begin
          stall = 1'b1;
          cnt_d = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
          if (cnt_q <= 2'd1) state_d = StResolve;
        end
      end
      StResolve: begin
        resolve = BRANCH_D;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
    // Hold every control quiet while reset is asserted, independent of the clock.
    if (!RST) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end
  end

  assign STALL_F  = stall;
  assign STALL_D  = stall;
  assign FLUSH_E  = stall;
  assign PC_SRC_D = resolve & (CMP_EQ ^ BNE_D);
  assign FLUSH_D  = PC_SRC_D;
  assign BUSY     = (state_q != StIdle);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q, br_taken_count_q, stall_count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      br_count_q       <= 16'd0;
      br_taken_count_q <= 16'd0;
      stall_count_q    <= 16'd0;
    end else begin
      if (resolve && br_count_q != 16'hFFFF) br_count_q <= br_count_q + 16'd1;
      if (PC_SRC_D && br_taken_count_q != 16'hFFFF) br_taken_count_q <= br_taken_count_q + 16'd1;
      if (STALL_D && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign BR_COUNT       = br_count_q;
  assign BR_TAKEN_COUNT = br_taken_count_q;
  assign STALL_COUNT    = stall_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Control outputs are compared as {STALL_F, STALL_D, FLUSH_E, PC_SRC_D, FLUSH_D, BUSY}.
module tb_branch_resolve_unit;

  localparam int unsigned WIDTH = 32;

  logic             CLK, RST;
  logic             BRANCH_D, BNE_D;
  logic [4:0]       RS_D, RT_D, WRITE_REG_E, WRITE_REG_M;
  logic [WIDTH-1:0] RD1_D, RD2_D, ALU_OUT_M;
  logic             REG_WRITE_E, MEM_TO_REG_E, REG_WRITE_M, MEM_TO_REG_M;
  logic [WIDTH-1:0] CMP_A, CMP_B;
  logic             CMP_EQ;
  logic             STALL_F, STALL_D, FLUSH_E, PC_SRC_D, FLUSH_D, BUSY;
`ifdef BRANCH_STATS_EN
  logic [15:0]      BR_COUNT, BR_TAKEN_COUNT, STALL_COUNT;
`endif

  int checks;
  int failures;

  logic [5:0] ctl;
  assign ctl = {STALL_F, STALL_D, FLUSH_E, PC_SRC_D, FLUSH_D, BUSY};

  branch_resolve_unit #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BRANCH_D     (BRANCH_D),
    .BNE_D        (BNE_D),
    .RS_D         (RS_D),
    .RT_D         (RT_D),
    .RD1_D        (RD1_D),
    .RD2_D        (RD2_D),
    .ALU_OUT_M    (ALU_OUT_M),
    .WRITE_REG_E  (WRITE_REG_E),
    .WRITE_REG_M  (WRITE_REG_M),
    .REG_WRITE_E  (REG_WRITE_E),
    .MEM_TO_REG_E (MEM_TO_REG_E),
    .REG_WRITE_M  (REG_WRITE_M),
    .MEM_TO_REG_M (MEM_TO_REG_M),
    .CMP_A        (CMP_A),
    .CMP_B        (CMP_B),
    .CMP_EQ       (CMP_EQ),
    .STALL_F      (STALL_F),
    .STALL_D      (STALL_D),
    .FLUSH_E      (FLUSH_E),
    .PC_SRC_D     (PC_SRC_D),
    .FLUSH_D      (FLUSH_D),
    .BUSY         (BUSY)
`ifdef BRANCH_STATS_EN
    ,
    .BR_COUNT       (BR_COUNT),
    .BR_TAKEN_COUNT (BR_TAKEN_COUNT),
    .STALL_COUNT    (STALL_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clr();
    BRANCH_D = 0; BNE_D = 0; RS_D = 0; RT_D = 0; RD1_D = 0; RD2_D = 0; ALU_OUT_M = 0;
    WRITE_REG_E = 0; WRITE_REG_M = 0; REG_WRITE_E = 0; MEM_TO_REG_E = 0;
    REG_WRITE_M = 0; MEM_TO_REG_M = 0; CMP_EQ = 0;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 0;
    clr();
    RD1_D = 32'h11; RD2_D = 32'h22;
    #12;
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    checks++;
    if (CMP_A !== 32'h11 || CMP_B !== 32'h22) begin
      failures++; $display("FAIL reset_cmp got=%h/%h exp=11/22", CMP_A, CMP_B);
    end
    RST = 1;
    step();
  endtask

  task automatic test_no_hazard();
    clr();
    BRANCH_D = 1; RS_D = 1; RT_D = 2; RD1_D = 5; RD2_D = 5; CMP_EQ = 1;
    #1;
    checks++;
    if (ctl !== 6'b000110) begin
      failures++; $display("FAIL beq_taken got=%b exp=%b", ctl, 6'b000110);
    end
    step();
    CMP_EQ = 0;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL beq_not_taken got=%b exp=%b", ctl, 6'b000000);
    end
    step();
  endtask

  task automatic test_ex_alu_hazard();
    clr();
    BRANCH_D = 1; RS_D = 3; RT_D = 7; RD1_D = 10; RD2_D = 20;
    REG_WRITE_E = 1; WRITE_REG_E = 3;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL alu_hz_c0 got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    REG_WRITE_E = 0; WRITE_REG_E = 0;
    REG_WRITE_M = 1; WRITE_REG_M = 3; ALU_OUT_M = 20; CMP_EQ = 1;
    #1;
    checks++;
    if (CMP_A !== 32'd20 || CMP_B !== 32'd20) begin
      failures++; $display("FAIL alu_hz_fwd got=%0d/%0d exp=20/20", CMP_A, CMP_B);
    end
    checks++;
    if (ctl !== 6'b000111) begin
      failures++; $display("FAIL alu_hz_c1 got=%b exp=%b", ctl, 6'b000111);
    end
    step();
    clr();
    #1;
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL alu_hz_idle got=%b exp=%b", ctl, 6'b000000);
    end
  endtask

  task automatic test_load_hazard_bne();
    clr();
    BRANCH_D = 1; BNE_D = 1; RS_D = 9; RT_D = 4; RD1_D = 7; RD2_D = 8;
    REG_WRITE_E = 1; MEM_TO_REG_E = 1; WRITE_REG_E = 4;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL lw_hz_c0 got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    REG_WRITE_E = 0; MEM_TO_REG_E = 0; WRITE_REG_E = 0;
    REG_WRITE_M = 1; MEM_TO_REG_M = 1; WRITE_REG_M = 4; ALU_OUT_M = 32'hDEAD;
    #1;
    checks++;
    if (ctl !== 6'b111001) begin
      failures++; $display("FAIL lw_hz_c1 got=%b exp=%b", ctl, 6'b111001);
    end
    checks++;
    if (CMP_B !== 32'd8) begin
      failures++; $display("FAIL lw_no_fwd got=%h exp=%h", CMP_B, 32'd8);
    end
    step();
    REG_WRITE_M = 0; MEM_TO_REG_M = 0; WRITE_REG_M = 0; RD2_D = 32'h55; CMP_EQ = 0;
    #1;
    checks++;
    if (ctl !== 6'b000111 || CMP_B !== 32'h55) begin
      failures++; $display("FAIL lw_hz_c2 got=%b/%h exp=%b/55", ctl, CMP_B, 6'b000111);
    end
    step();
    clr();
  endtask

  task automatic test_zero_reg();
    clr();
    BRANCH_D = 1; RS_D = 0; RT_D = 2; RD1_D = 32'h33; RD2_D = 32'h33; CMP_EQ = 1;
    REG_WRITE_E = 1; MEM_TO_REG_E = 1; WRITE_REG_E = 0;
    REG_WRITE_M = 1; WRITE_REG_M = 0; ALU_OUT_M = 32'h99;
    #1;
    checks++;
    if (ctl !== 6'b000110) begin
      failures++; $display("FAIL zero_reg_ctl got=%b exp=%b", ctl, 6'b000110);
    end
    checks++;
    if (CMP_A !== 32'h33) begin
      failures++; $display("FAIL zero_reg_fwd got=%h exp=33", CMP_A);
    end
    step();
    clr();
  endtask

  task automatic test_dual_hazard();
    clr();
    BRANCH_D = 1; RS_D = 5; RT_D = 6; RD1_D = 1; RD2_D = 2;
    REG_WRITE_M = 1; MEM_TO_REG_M = 1; WRITE_REG_M = 5;
    REG_WRITE_E = 1; MEM_TO_REG_E = 1; WRITE_REG_E = 6;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL dual_c0 got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    checks++;
    if (ctl !== 6'b111001) begin
      failures++; $display("FAIL dual_c1 got=%b exp=%b", ctl, 6'b111001);
    end
    step();
    checks++;
    if (ctl !== 6'b000001) begin
      failures++; $display("FAIL dual_c2 got=%b exp=%b", ctl, 6'b000001);
    end
    step();
    // Back in IDLE with the same hazards visible: a fresh evaluation stalls again.
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL back_to_back got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    clr();
    #1;
    checks++;
    if (ctl !== 6'b000001) begin
      failures++; $display("FAIL stall_drop got=%b exp=%b", ctl, 6'b000001);
    end
    step();
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL stall_drop_idle got=%b exp=%b", ctl, 6'b000000);
    end
  endtask

  task automatic test_same_reg();
    clr();
    BRANCH_D = 1; RS_D = 5; RT_D = 5; RD1_D = 4; RD2_D = 4; CMP_EQ = 1;
    REG_WRITE_E = 1; WRITE_REG_E = 5;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL same_reg_c0 got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    checks++;
    if (ctl !== 6'b000111) begin
      failures++; $display("FAIL same_reg_c1 got=%b exp=%b", ctl, 6'b000111);
    end
    step();
    clr();
  endtask

  task automatic test_external_flush();
    clr();
    BRANCH_D = 1; RS_D = 3; REG_WRITE_E = 1; WRITE_REG_E = 3;
    #1;
    checks++;
    if (ctl !== 6'b111000) begin
      failures++; $display("FAIL xflush_c0 got=%b exp=%b", ctl, 6'b111000);
    end
    step();
    clr();
    CMP_EQ = 1;
    #1;
    checks++;
    if (ctl !== 6'b000001) begin
      failures++; $display("FAIL xflush_c1 got=%b exp=%b", ctl, 6'b000001);
    end
    step();
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL xflush_idle got=%b exp=%b", ctl, 6'b000000);
    end
  endtask

  task automatic test_reset_mid_stall();
    clr();
    BRANCH_D = 1; RT_D = 4; REG_WRITE_E = 1; MEM_TO_REG_E = 1; WRITE_REG_E = 4;
    step();
    checks++;
    if (ctl !== 6'b111001) begin
      failures++; $display("FAIL rst_mid_pre got=%b exp=%b", ctl, 6'b111001);
    end
    RST = 0;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin
      failures++; $display("FAIL rst_mid_async got=%b exp=%b", ctl, 6'b000000);
    end
    step();
    RST = 1;
    clr();
    BRANCH_D = 1; RS_D = 1; RT_D = 2; CMP_EQ = 1;
    #1;
    checks++;
    if (ctl !== 6'b000110) begin
      failures++; $display("FAIL rst_mid_after got=%b exp=%b", ctl, 6'b000110);
    end
    step();
    clr();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    RST = 0;
    clr();
    #2;
    RST = 1;
    step();
    BRANCH_D = 1; RS_D = 1; RT_D = 2; CMP_EQ = 1;
    step();
    BNE_D = 1; REG_WRITE_E = 1; MEM_TO_REG_E = 1; WRITE_REG_E = 1;
    step();
    REG_WRITE_E = 0; MEM_TO_REG_E = 0;
    step();
    step();
    BNE_D = 0; CMP_EQ = 0;
    step();
    clr();
    step();
    checks++;
    if (BR_COUNT !== 16'd3 || BR_TAKEN_COUNT !== 16'd1 || STALL_COUNT !== 16'd2) begin
      failures++;
      $display("FAIL stats_counts got=%0d/%0d/%0d exp=3/1/2", BR_COUNT, BR_TAKEN_COUNT,
               STALL_COUNT);
    end
    BRANCH_D = 1; RS_D = 1; RT_D = 2; CMP_EQ = 1;
    repeat (65540) @(posedge CLK);
    #1;
    clr();
    checks++;
    if (BR_COUNT !== 16'hFFFF || BR_TAKEN_COUNT !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate got=%h/%h exp=ffff/ffff", BR_COUNT, BR_TAKEN_COUNT);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_no_hazard();
    test_ex_alu_hazard();
    test_load_hazard_bne();
    test_zero_reg();
    test_dual_hazard();
    test_same_reg();
    test_external_flush();
    test_reset_mid_stall();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
